// File: rtl/asym_fifo_pkg.sv
// Shared constant helpers for the asymmetric-width FIFO and its storage RAM.
// All functions are elaboration-time only.
package asym_fifo_pkg;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int ratio(input int a, input int b);
        return max_i(a, b) / min_i(a, b);
    endfunction

    function automatic int log2_i(input int v);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= v) return r;
        end
        return 31;
    endfunction

    // Legal when the wide/narrow ratio is an exact power of two that fits twice in the RAM.
    function automatic bit params_ok(input int dwi, input int dwo, input int aw);
        int r;
        if (dwi <= 0 || dwo <= 0 || aw < 1 || aw > 30) return 1'b0;
        if (max_i(dwi, dwo) % min_i(dwi, dwo) != 0) return 1'b0;
        r = ratio(dwi, dwo);
        return ((1 << log2_i(r)) == r) && (r <= (1 << (aw - 1)));
    endfunction

endpackage

// File: rtl/asym_sdp_ram_1clk.sv
// Single-clock simple-dual-port RAM, DWI-wide write and DWO-wide registered read,
// stored as CAP minimum-width units with little-endian lane order.
module asym_sdp_ram_1clk
    import asym_fifo_pkg::*;
#(
    parameter int DWI = 16,
    parameter int DWO = 4,
    parameter int AW  = 10
) (
    input  logic           clk,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [DWI-1:0] wdata,
    input  logic           re,
    input  logic [AW-1:0]  raddr,
    output logic [DWO-1:0] rdata
);

    localparam int MIN_DW = min_i(DWI, DWO);
    localparam int UI     = DWI / MIN_DW;
    localparam int UO     = DWO / MIN_DW;
    localparam int CAP    = 1 << AW;

    logic [MIN_DW-1:0] mem [CAP];

    // Addresses are always lane-aligned, so the unit offsets never carry across a word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < UI; i++) begin
                mem[waddr + AW'(i)] <= wdata[i*MIN_DW +: MIN_DW];
            end
        end
        if (re) begin
            for (int j = 0; j < UO; j++) begin
                rdata[j*MIN_DW +: MIN_DW] <= mem[raddr + AW'(j)];
            end
        end
    end

endmodule

// File: rtl/asym_sync_fifo.sv
// Single-clock width-converting FIFO: unit-addressed RAM, read-issue control
// and a 2-entry output buffer that decouples the registered RAM read from m_ready.
module asym_sync_fifo
    import asym_fifo_pkg::*;
#(
    parameter int DWI = 16,
    parameter int DWO = 4,
    parameter int AW  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [DWI-1:0] s_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [DWO-1:0] m_data,
    output logic [AW:0]    level
);

    localparam int MIN_DW = min_i(DWI, DWO);
    localparam int UI     = DWI / MIN_DW;
    localparam int UO     = DWO / MIN_DW;
    localparam int CAP    = 1 << AW;

    localparam logic [AW:0]   UI_L  = (AW+1)'(UI);
    localparam logic [AW:0]   UO_L  = (AW+1)'(UO);
    localparam logic [AW:0]   CAP_L = (AW+1)'(CAP);
    localparam logic [AW-1:0] UI_P  = AW'(UI);
    localparam logic [AW-1:0] UO_P  = AW'(UO);

    if (!params_ok(DWI, DWO, AW)) begin : g_param_err
        $error("asym_sync_fifo: illegal DWI/DWO/AW combination");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   level_nxt;
    logic [1:0]    buf_cnt;
    logic          inflight;
    logic [DWO-1:0] buf_q [2];
    logic [DWO-1:0] rdata;
    logic [2:0]    occ;
    logic          wr_acc;
    logic          pop;
    logic          issue;

    assign wr_acc  = s_valid & s_ready;
    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf_q[0];
    assign pop     = m_valid & m_ready;

    // A pop in this cycle frees a buffer slot in time for a read issued now.
    assign occ   = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue = (ram_cnt >= UO_L) && (occ < 3'd2);

    assign level_nxt = level + (wr_acc ? UI_L : '0) - (pop ? UO_L : '0);

    asym_sdp_ram_1clk #(
        .DWI (DWI),
        .DWO (DWO),
        .AW  (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (s_data),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            level    <= '0;
            s_ready  <= 1'b0;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            ram_cnt  <= '0;
            level    <= '0;
            s_ready  <= 1'b1;
            inflight <= 1'b0;
            buf_cnt  <= 2'd0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + UI_P;
            if (issue)  rd_ptr <= rd_ptr + UO_P;
            ram_cnt  <= ram_cnt + (wr_acc ? UI_L : '0) - (issue ? UO_L : '0);
            level    <= level_nxt;
            s_ready  <= (level_nxt <= CAP_L - UI_L);
            inflight <= issue;

            // Issue control guarantees at most one buffered entry whenever a read returns.
            case ({inflight, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) buf_q[0] <= rdata;
                    else                 buf_q[1] <= rdata;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf_q[0] <= buf_q[1];
                    buf_cnt  <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf_q[0] <= rdata;
                    end else begin
                        buf_q[0] <= buf_q[1];
                        buf_q[1] <= rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_asym_sync_fifo.sv
// Directed bench for asym_sync_fifo: a 16->4 unpacking instance (a_*) and a
// 4->16 packing instance (b_*), both with 1024-unit capacity.
module tb_asym_sync_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_clr = 1'b0, a_s_valid = 1'b0, a_m_ready = 1'b0;
    logic        a_s_ready, a_m_valid;
    logic [15:0] a_s_data = '0;
    logic [3:0]  a_m_data;
    logic [10:0] a_level;

    logic        b_clr = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b0;
    logic        b_s_ready, b_m_valid;
    logic [3:0]  b_s_data = '0;
    logic [15:0] b_m_data;
    logic [10:0] b_level;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    asym_sync_fifo #(.DWI(16), .DWO(4), .AW(10)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .level(a_level)
    );

    asym_sync_fifo #(.DWI(4), .DWO(16), .AW(10)) u_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .level(b_level)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (a_s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", a_s_ready); else n_pass++;
        n_total++; if (a_m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", a_m_valid); else n_pass++;
        n_total++; if (a_m_data !== 4'h0) $display("FAIL reset_m_data: got %h want 0", a_m_data); else n_pass++;
        n_total++; if (a_level !== 11'd0) $display("FAIL reset_level: got %0d want 0", a_level); else n_pass++;
        n_total++; if (b_s_ready !== 1'b0) $display("FAIL reset_b_s_ready: got %b want 0", b_s_ready); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if ({a_s_ready, b_s_ready} !== 2'b11) $display("FAIL reset_release_s_ready: got %b want 11", {a_s_ready, b_s_ready}); else n_pass++;
    endtask

    task automatic test_unpack();
        logic [3:0] exp_n [4] = '{4'h3, 4'hC, 4'h5, 4'hA};
        a_s_valid = 1'b1; a_s_data = 16'hA5C3;
        @(negedge clk);
        a_s_valid = 1'b0; a_s_data = 16'hFFFF;
        n_total++; if (a_m_valid !== 1'b0) $display("FAIL unpack_lat1: m_valid got %b want 0", a_m_valid); else n_pass++;
        n_total++; if (a_level !== 11'd4) $display("FAIL unpack_level: got %0d want 4", a_level); else n_pass++;
        @(negedge clk);
        n_total++; if (a_m_valid !== 1'b0) $display("FAIL unpack_lat2: m_valid got %b want 0", a_m_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (a_m_valid !== 1'b1) $display("FAIL unpack_lat3: m_valid got %b want 1", a_m_valid); else n_pass++;
        a_m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({a_m_valid, a_m_data} !== {1'b1, exp_n[i]})
                $display("FAIL unpack_lane%0d: got v=%b d=%h want v=1 d=%h", i, a_m_valid, a_m_data, exp_n[i]);
            else n_pass++;
            @(negedge clk);
        end
        a_m_ready = 1'b0;
        n_total++; if ({a_m_valid, a_level} !== {1'b0, 11'd0}) $display("FAIL unpack_empty: got v=%b lvl=%0d want v=0 lvl=0", a_m_valid, a_level); else n_pass++;
    endtask

    task automatic test_pack();
        b_s_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            b_s_data = 4'(i);
            @(negedge clk);
        end
        b_s_valid = 1'b0;
        n_total++; if (b_level !== 11'd3) $display("FAIL pack_level3: got %0d want 3", b_level); else n_pass++;
        repeat (4) @(negedge clk);
        n_total++; if (b_m_valid !== 1'b0) $display("FAIL pack_partial: m_valid got %b want 0", b_m_valid); else n_pass++;
        b_s_valid = 1'b1; b_s_data = 4'h4;
        @(negedge clk);
        b_s_valid = 1'b0;
        n_total++; if (b_level !== 11'd4) $display("FAIL pack_level4: got %0d want 4", b_level); else n_pass++;
        @(negedge clk);
        n_total++; if (b_m_valid !== 1'b0) $display("FAIL pack_lat2: m_valid got %b want 0", b_m_valid); else n_pass++;
        @(negedge clk);
        n_total++;
        if ({b_m_valid, b_m_data} !== {1'b1, 16'h4321}) $display("FAIL pack_word: got v=%b d=%h want v=1 d=4321", b_m_valid, b_m_data);
        else n_pass++;
        b_m_ready = 1'b1;
        @(negedge clk);
        b_m_ready = 1'b0;
        n_total++; if ({b_m_valid, b_level} !== {1'b0, 11'd0}) $display("FAIL pack_empty: got v=%b lvl=%0d want v=0 lvl=0", b_m_valid, b_level); else n_pass++;
    endtask

    task automatic test_clr();
        logic [3:0] exp_n [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
        a_s_valid = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            a_s_data = 16'(16'h1111 * i);
            @(negedge clk);
        end
        a_s_data = 16'hFFFF; a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0; a_s_valid = 1'b0;
        n_total++;
        if ({a_m_valid, a_s_ready, a_level} !== {1'b0, 1'b1, 11'd0})
            $display("FAIL clr_state: got v=%b rdy=%b lvl=%0d want v=0 rdy=1 lvl=0", a_m_valid, a_s_ready, a_level);
        else n_pass++;
        @(negedge clk);
        n_total++; if ({a_m_valid, a_level} !== {1'b0, 11'd0}) $display("FAIL clr_discard: got v=%b lvl=%0d want v=0 lvl=0", a_m_valid, a_level); else n_pass++;
        a_s_valid = 1'b1; a_s_data = 16'h0F0F;
        @(negedge clk);
        a_s_valid = 1'b0;
        repeat (2) @(negedge clk);
        a_m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if ({a_m_valid, a_m_data} !== {1'b1, exp_n[i]})
                $display("FAIL clr_after_lane%0d: got v=%b d=%h want v=1 d=%h", i, a_m_valid, a_m_data, exp_n[i]);
            else n_pass++;
            @(negedge clk);
        end
        a_m_ready = 1'b0;
    endtask

    task automatic test_full_b();
        int acc = 0;
        int popped = 1;
        int err = 0;
        logic [15:0] exp_w;
        b_m_ready = 1'b0; b_s_valid = 1'b1;
        for (int c = 0; c < 1100; c++) begin
            if (!b_s_ready) break;
            b_s_data = 4'(acc);
            acc++;
            @(negedge clk);
        end
        b_s_valid = 1'b0;
        n_total++; if (acc != 1024) $display("FAIL full_b_accepts: got %0d want 1024", acc); else n_pass++;
        n_total++; if ({b_s_ready, b_level} !== {1'b0, 11'd1024}) $display("FAIL full_b_state: got rdy=%b lvl=%0d want rdy=0 lvl=1024", b_s_ready, b_level); else n_pass++;
        n_total++; if ({b_m_valid, b_m_data} !== {1'b1, 16'h3210}) $display("FAIL full_b_head: got v=%b d=%h want v=1 d=3210", b_m_valid, b_m_data); else n_pass++;
        b_m_ready = 1'b1;
        @(negedge clk);
        b_m_ready = 1'b0;
        n_total++; if ({b_s_ready, b_level} !== {1'b1, 11'd1020}) $display("FAIL full_b_one_pop: got rdy=%b lvl=%0d want rdy=1 lvl=1020", b_s_ready, b_level); else n_pass++;
        b_m_ready = 1'b1;
        for (int c = 0; c < 2000 && popped < 256; c++) begin
            if (b_m_valid) begin
                exp_w = {4'(4*popped+3), 4'(4*popped+2), 4'(4*popped+1), 4'(4*popped)};
                if (b_m_data !== exp_w) err++;
                popped++;
            end
            @(negedge clk);
        end
        b_m_ready = 1'b0;
        n_total++;
        if (popped != 256 || err != 0 || b_level !== 11'd0)
            $display("FAIL full_b_drain: got words=%0d errs=%0d lvl=%0d want words=256 errs=0 lvl=0", popped, err, b_level);
        else n_pass++;
    endtask

    task automatic test_full_a();
        int acc = 0;
        a_m_ready = 1'b0; a_s_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!a_s_ready) break;
            a_s_data = 16'(acc * 3);
            acc++;
            @(negedge clk);
        end
        a_s_valid = 1'b0;
        n_total++; if (acc != 256) $display("FAIL full_a_accepts: got %0d want 256", acc); else n_pass++;
        a_m_ready = 1'b1;
        repeat (3) @(negedge clk);
        a_m_ready = 1'b0;
        n_total++; if ({a_s_ready, a_level} !== {1'b0, 11'd1021}) $display("FAIL full_a_three_pops: got rdy=%b lvl=%0d want rdy=0 lvl=1021", a_s_ready, a_level); else n_pass++;
        a_m_ready = 1'b1;
        @(negedge clk);
        a_m_ready = 1'b0;
        n_total++; if ({a_s_ready, a_level} !== {1'b1, 11'd1020}) $display("FAIL full_a_four_pops: got rdy=%b lvl=%0d want rdy=1 lvl=1020", a_s_ready, a_level); else n_pass++;
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] q [$];
        int sent = 0, rx = 0, err = 0, hold_err = 0;
        logic prev_hold = 1'b0;
        logic [3:0] prev_data = '0;
        for (int c = 0; c < 40000 && rx < 8000; c++) begin
            a_s_valid = (sent < 2000) && ($urandom_range(1) == 1);
            a_s_data  = 16'($urandom);
            a_m_ready = ($urandom_range(1) == 1);
            if (prev_hold && (!a_m_valid || a_m_data !== prev_data)) hold_err++;
            if (a_s_valid && a_s_ready) begin
                for (int i = 0; i < 4; i++) q.push_back(a_s_data[i*4 +: 4]);
                sent++;
            end
            if (a_m_valid && a_m_ready) begin
                if (q.size() == 0) err++;
                else if (a_m_data !== q.pop_front()) err++;
                rx++;
            end
            prev_hold = a_m_valid && !a_m_ready;
            prev_data = a_m_data;
            @(negedge clk);
        end
        a_s_valid = 1'b0; a_m_ready = 1'b0;
        n_total++; if (rx != 8000 || err != 0) $display("FAIL random_stream: got units=%0d errs=%0d want units=8000 errs=0", rx, err); else n_pass++;
        n_total++; if (hold_err != 0) $display("FAIL random_hold: got %0d unstable cycles want 0", hold_err); else n_pass++;
        n_total++; if (a_level !== 11'd0) $display("FAIL random_level: got %0d want 0", a_level); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int w = 0, n = 0, gaps = 0, err = 0, stalls = 0, rx = 0;
        logic started = 1'b0;
        a_s_valid = 1'b1; a_m_ready = 1'b1;
        for (int c = 0; c < 700; c++) begin
            if (a_s_ready) begin
                a_s_data = {4'(4*w+3), 4'(4*w+2), 4'(4*w+1), 4'(4*w)};
                w++;
            end
            if (a_m_valid) begin
                started = 1'b1;
                if (a_m_data !== 4'(n)) err++;
                n++;
            end else if (started) gaps++;
            @(negedge clk);
        end
        a_s_valid = 1'b0;
        n_total++; if (n != 697 || gaps != 0 || err != 0) $display("FAIL b2b_a_stream: got units=%0d gaps=%0d errs=%0d want 697/0/0", n, gaps, err); else n_pass++;
        n_total++; if (a_level <= 11'd1016) $display("FAIL b2b_a_full: got level %0d want above 1016", a_level); else n_pass++;
        a_m_ready = 1'b0; a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;

        n = 0;
        b_s_valid = 1'b1; b_m_ready = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!b_s_ready) stalls++;
            b_s_data = 4'(n);
            if (b_s_ready) n++;
            if (b_m_valid) begin
                if (b_m_data !== {4'(4*rx+3), 4'(4*rx+2), 4'(4*rx+1), 4'(4*rx)}) err++;
                rx++;
            end
            @(negedge clk);
        end
        b_s_valid = 1'b0; b_m_ready = 1'b0;
        n_total++; if (stalls != 0 || rx != 99 || err != 0) $display("FAIL b2b_b_stream: got stalls=%0d words=%0d errs=%0d want 0/99/0", stalls, rx, err); else n_pass++;
        b_clr = 1'b1;
        @(negedge clk);
        b_clr = 1'b0;
    endtask

    task automatic test_midreset();
        a_s_valid = 1'b1; a_m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            a_s_data = 16'(16'h1357 * (c + 1));
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({a_s_ready, a_m_valid, a_m_data, a_level} !== {1'b0, 1'b0, 4'h0, 11'd0})
            $display("FAIL midreset_async: got rdy=%b v=%b d=%h lvl=%0d want 0/0/0/0", a_s_ready, a_m_valid, a_m_data, a_level);
        else n_pass++;
        a_s_valid = 1'b0; a_m_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (a_s_ready !== 1'b1) $display("FAIL midreset_release: s_ready got %b want 1", a_s_ready); else n_pass++;
        test_unpack();
    endtask

    initial begin
        test_reset();
        test_unpack();
        test_pack();
        test_clr();
        test_full_b();
        test_full_a();
        test_random();
        test_back_to_back();
        test_midreset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
